// File: rtl/alu16_seq_pkg.sv
// Shared definitions for the 16-bit arithmetic sequencer and the 8-bit ALU.
package alu16_seq_pkg;

    // 8-bit ALU operation codes
    localparam logic [5:0] ALU_ADD = 6'h00;
    localparam logic [5:0] ALU_ADC = 6'h01;
    localparam logic [5:0] ALU_SUB = 6'h02;
    localparam logic [5:0] ALU_SBC = 6'h03;

    // Flag bit positions within {Z,N,H,C}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    // 16-bit sequencer operation codes
    localparam logic [1:0] OP16_ADD   = 2'd0;
    localparam logic [1:0] OP16_ADDSP = 2'd1;
    localparam logic [1:0] OP16_INC   = 2'd2;
    localparam logic [1:0] OP16_DEC   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU: ADD, ADC, SUB, SBC with SM83-style {Z,N,H,C} flags.
// Unsupported op codes pass operand A and the incoming flags through unchanged.
module alu
    import alu16_seq_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [5:0] op,
    input  logic [3:0] flags_in,
    output logic [7:0] result,
    output logic [3:0] flags_out
);

    logic       cin;
    logic [8:0] full;
    logic [4:0] half;

    // Byte arithmetic with carry/borrow out of bit 3 (H) and bit 7 (C)
    always_comb begin
        cin       = 1'b0;
        full      = {1'b0, a};
        half      = {1'b0, a[3:0]};
        result    = a;
        flags_out = flags_in;
        case (op)
            ALU_ADD, ALU_ADC: begin
                cin       = (op == ALU_ADC) ? flags_in[FLAG_C] : 1'b0;
                full      = {1'b0, a} + {1'b0, b} + {8'd0, cin};
                half      = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin};
                result    = full[7:0];
                flags_out = {(full[7:0] == 8'd0), 1'b0, half[4], full[8]};
            end
            ALU_SUB, ALU_SBC: begin
                cin       = (op == ALU_SBC) ? flags_in[FLAG_C] : 1'b0;
                full      = {1'b0, a} - {1'b0, b} - {8'd0, cin};
                half      = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'd0, cin};
                result    = full[7:0];
                flags_out = {(full[7:0] == 8'd0), 1'b1, half[4], full[8]};
            end
            default: begin
                result    = a;
                flags_out = flags_in;
            end
        endcase
    end

endmodule

// File: rtl/alu16_seq.sv
// 16-bit arithmetic sequencer: runs the shared 8-bit ALU twice (low byte,
// then high byte with carry chained) for ADD HL,rr / ADD SP,e8 / INC rr / DEC rr.
// Handshake: start is a one-cycle request honoured only in IDLE or DONE; the
// operands are captured on that edge, busy/alu_own cover the two byte cycles,
// and done pulses for one cycle with result/flags_out valid.
module alu16_seq
    import alu16_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    input  logic [3:0]  flags_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [3:0]  flags_out,
    output logic        alu_own,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [5:0]  alu_op,
    output logic [3:0]  alu_flags_in,
    input  logic [7:0]  alu_result,
    input  logic [3:0]  alu_flags_out
);

    seq_state_t  state;
    logic [1:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [3:0]  flags_q;
    logic [7:0]  lo_res;
    logic [3:0]  lo_flags;
    logic [3:0]  new_flags;
    logic [1:0]  unused_lo_zn;

    // Only H and C of the low-byte step feed anything downstream
    assign unused_lo_zn = lo_flags[FLAG_Z:FLAG_N];

    assign alu_own = busy;

    // ALU operand drive for the current byte step; quiet when not owning the ALU
    always_comb begin
        alu_a        = 8'h00;
        alu_b        = 8'h00;
        alu_op       = 6'h00;
        alu_flags_in = 4'h0;
        case (state)
            ST_LO: begin
                alu_a        = a_q[7:0];
                alu_flags_in = {flags_q[3:1], 1'b0};
                case (op_q)
                    OP16_ADD:   begin alu_b = b_q[7:0];  alu_op = ALU_ADD; end
                    OP16_ADDSP: begin alu_b = b_q[7:0];  alu_op = ALU_ADD; end
                    OP16_INC:   begin alu_b = 8'h01;     alu_op = ALU_ADD; end
                    default:    begin alu_b = 8'h01;     alu_op = ALU_SUB; end
                endcase
            end
            ST_HI: begin
                alu_a        = a_q[15:8];
                alu_flags_in = {flags_q[3:1], lo_flags[FLAG_C]};
                case (op_q)
                    OP16_ADD:   begin alu_b = b_q[15:8];      alu_op = ALU_ADC; end
                    OP16_ADDSP: begin alu_b = {8{b_q[7]}};    alu_op = ALU_ADC; end
                    OP16_INC:   begin alu_b = 8'h00;          alu_op = ALU_ADC; end
                    default:    begin alu_b = 8'h00;          alu_op = ALU_SBC; end
                endcase
            end
            default: ;
        endcase
    end

    // Flags reported at the end of the HI step, selected by operation
    always_comb begin
        new_flags = flags_q;
        case (op_q)
            OP16_ADD:   new_flags = {flags_q[FLAG_Z], 1'b0, alu_flags_out[FLAG_H], alu_flags_out[FLAG_C]};
            OP16_ADDSP: new_flags = {2'b00, lo_flags[FLAG_H], lo_flags[FLAG_C]};
            default:    new_flags = flags_q;
        endcase
    end

    // Sequencer FSM with registered status and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            op_q      <= 2'd0;
            a_q       <= 16'h0000;
            b_q       <= 16'h0000;
            flags_q   <= 4'h0;
            lo_res    <= 8'h00;
            lo_flags  <= 4'h0;
            result    <= 16'h0000;
            flags_out <= 4'h0;
        end else begin
            case (state)
                ST_LO: begin
                    lo_res   <= alu_result;
                    lo_flags <= alu_flags_out;
                    state    <= ST_HI;
                end
                ST_HI: begin
                    result    <= {alu_result, lo_res};
                    flags_out <= new_flags;
                    state     <= ST_DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q    <= op;
                        a_q     <= a_in;
                        b_q     <= b_in;
                        flags_q <= flags_in;
                        state   <= ST_LO;
                        busy    <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu16_seq.sv
// Bench for alu16_seq paired with the real 8-bit alu.
module tb_alu16_seq;
    import alu16_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [3:0]  flags_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [3:0]  flags_out;
    logic        alu_own;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [5:0]  alu_op;
    logic [3:0]  alu_flags_in;
    logic [7:0]  alu_result;
    logic [3:0]  alu_flags_out;

    logic [19:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    alu16_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .flags_in(flags_in), .busy(busy), .done(done), .result(result),
        .flags_out(flags_out), .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_flags_in(alu_flags_in), .alu_result(alu_result),
        .alu_flags_out(alu_flags_out)
    );

    alu u_alu (
        .a(alu_a), .b(alu_b), .op(alu_op), .flags_in(alu_flags_in),
        .result(alu_result), .flags_out(alu_flags_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole 16-bit arithmetic, flags from bit-11/bit-15 (ADD16)
    // or bit-3/bit-7 (ADDSP) carries.
    function automatic logic [19:0] model(input logic [1:0] m_op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [3:0] f);
        logic [16:0] s;
        logic [12:0] h12;
        logic [4:0]  h4;
        logic [8:0]  c8;
        logic [15:0] r;
        logic [3:0]  nf;
        r  = a;
        nf = f;
        case (m_op)
            2'd0: begin
                s   = {1'b0, a} + {1'b0, b};
                h12 = {1'b0, a[11:0]} + {1'b0, b[11:0]};
                r   = s[15:0];
                nf  = {f[3], 1'b0, h12[12], s[16]};
            end
            2'd1: begin
                r  = a + {{8{b[7]}}, b[7:0]};
                h4 = {1'b0, a[3:0]} + {1'b0, b[3:0]};
                c8 = {1'b0, a[7:0]} + {1'b0, b[7:0]};
                nf = {2'b00, h4[4], c8[8]};
            end
            2'd2: r = a + 16'd1;
            default: r = a - 16'd1;
        endcase
        return {r, nf};
    endfunction

    // driver: present one request at the negedge, hold start across one edge
    task automatic send_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] f);
        @(negedge clk);
        op = o; a_in = a; b_in = b; flags_in = f; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        exp_q.push_back(model(o, a, b, f));
    endtask

    // bounded wait for done; lat counts negedges after the accept edge
    task automatic wait_done(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; op = 2'd0; a_in = 16'h1111; b_in = 16'h2222; flags_in = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, alu_own} !== 3'b000) begin
            errors++; $display("FAIL reset_status got %b exp 000", {busy, done, alu_own});
        end
        checks++;
        if ({result, flags_out} !== 20'h0) begin
            errors++; $display("FAIL reset_result got %h exp 00000", {result, flags_out});
        end
        checks++;
        if ({alu_a, alu_b, alu_op, alu_flags_in} !== 26'h0) begin
            errors++; $display("FAIL reset_alu_drive got %h exp 0", {alu_a, alu_b, alu_op, alu_flags_in});
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle_busy got %b exp 0", busy);
        end
    endtask

    task automatic test_vectors;
        logic [1:0]  t_op [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
        logic [15:0] t_a  [7] = '{16'h0FFF, 16'hFFFF, 16'hFFF8, 16'h0005, 16'h00FF, 16'h0000, 16'h8000};
        logic [15:0] t_b  [7] = '{16'h0001, 16'h0001, 16'h0008, 16'h00FE, 16'h1234, 16'h5555, 16'h0000};
        logic [3:0]  t_f  [7] = '{4'h8, 4'h0, 4'hF, 4'h0, 4'h5, 4'h6, 4'hA};
        logic [15:0] t_r  [7] = '{16'h1000, 16'h0000, 16'h0000, 16'h0003, 16'h0100, 16'hFFFF, 16'h7FFF};
        logic [3:0]  t_rf [7] = '{4'hA, 4'h3, 4'h3, 4'h3, 4'h5, 4'h6, 4'hA};
        int lat;
        bit ok;
        logic [19:0] e;
        for (int i = 0; i < 7; i++) begin
            send_op(t_op[i], t_a[i], t_b[i], t_f[i]);
            wait_done(lat, ok);
            checks++;
            if (!ok || lat != 3) begin
                errors++; $display("FAIL vec%0d_latency got %0d exp 3 (done seen %0d)", i, lat, ok);
            end
            checks++;
            if ({result, flags_out} !== {t_r[i], t_rf[i]}) begin
                errors++; $display("FAIL vec%0d_result got %h/%h exp %h/%h", i, result, flags_out, t_r[i], t_rf[i]);
            end
            e = exp_q.pop_front();
            checks++;
            if ({result, flags_out} !== e) begin
                errors++; $display("FAIL vec%0d_model got %h exp %h", i, {result, flags_out}, e);
            end
        end
    endtask

    task automatic test_random;
        int lat;
        bit ok;
        logic [19:0] e;
        for (int i = 0; i < 24; i++) begin
            send_op(2'($urandom_range(3, 0)), 16'($urandom_range(16'hFFFF, 0)),
                    16'($urandom_range(16'hFFFF, 0)), 4'($urandom_range(15, 0)));
            wait_done(lat, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || {result, flags_out} !== e) begin
                errors++; $display("FAIL rand%0d got %h exp %h (done seen %0d)", i, {result, flags_out}, e, ok);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++; $display("FAIL rand%0d_done_pulse got %b exp 0", i, done);
            end
        end
    endtask

    task automatic test_start_ignored;
        logic [19:0] e;
        @(negedge clk);
        op = OP16_ADD; a_in = 16'h1234; b_in = 16'h1111; flags_in = 4'h0; start = 1'b1;
        exp_q.push_back(model(OP16_ADD, 16'h1234, 16'h1111, 4'h0));
        @(posedge clk);
        #1 a_in = 16'hFFFF; b_in = 16'hFFFF; op = OP16_DEC; flags_in = 4'hF;
        @(negedge clk);
        checks++;
        if ({busy, alu_own, done} !== 3'b110) begin
            errors++; $display("FAIL hold_lo_status got %b exp 110", {busy, alu_own, done});
        end
        @(negedge clk);
        checks++;
        if ({busy, alu_own, done} !== 3'b110) begin
            errors++; $display("FAIL hold_hi_status got %b exp 110", {busy, alu_own, done});
        end
        @(negedge clk);
        start = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if ({done, busy, alu_own, result, flags_out} !== {3'b100, e}) begin
            errors++; $display("FAIL hold_done got %b/%h exp 100/%h", {done, busy, alu_own}, {result, flags_out}, e);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({busy, done, alu_own} !== 3'b000) begin
                errors++; $display("FAIL hold_no_extra_op got %b exp 000", {busy, done, alu_own});
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] ba [3] = '{16'h00FF, 16'hABCD, 16'h0100};
        logic [15:0] bb [3] = '{16'h0001, 16'h5433, 16'h0000};
        logic [1:0]  bo [3] = '{OP16_ADD, OP16_ADD, OP16_DEC};
        logic [19:0] e;
        logic [19:0] prev;
        int lat;
        bit ok;
        send_op(bo[0], ba[0], bb[0], 4'h0);
        wait_done(lat, ok);
        for (int i = 1; i < 3; i++) begin
            e = exp_q.pop_front();
            prev = e;
            checks++;
            if (!ok || {result, flags_out} !== e) begin
                errors++; $display("FAIL b2b%0d_first got %h exp %h", i, {result, flags_out}, e);
            end
            op = bo[i]; a_in = ba[i]; b_in = bb[i]; flags_in = 4'h9; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            exp_q.push_back(model(bo[i], ba[i], bb[i], 4'h9));
            lat = 0;
            ok  = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                lat++;
                if (done) begin
                    ok = 1'b1;
                    break;
                end
                checks++;
                if ({result, flags_out} !== prev) begin
                    errors++; $display("FAIL b2b%0d_hold got %h exp %h", i, {result, flags_out}, prev);
                end
            end
            checks++;
            if (!ok || lat != 3) begin
                errors++; $display("FAIL b2b%0d_latency got %0d exp 3", i, lat);
            end
        end
        e = exp_q.pop_front();
        checks++;
        if ({result, flags_out} !== e) begin
            errors++; $display("FAIL b2b_last got %h exp %h", {result, flags_out}, e);
        end
    endtask

    task automatic test_reset_mid;
        logic [19:0] e;
        int lat;
        bit ok;
        bit saw_done;
        send_op(OP16_ADD, 16'h1234, 16'h0001, 4'h8);
        wait_done(lat, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || {result, flags_out} !== e) begin
            errors++; $display("FAIL rmid_pre got %h exp %h", {result, flags_out}, e);
        end
        send_op(OP16_ADD, 16'h2222, 16'h1111, 4'h0);
        void'(exp_q.pop_front());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, alu_own} !== 3'b000 || {result, flags_out} !== 20'h0) begin
            errors++; $display("FAIL rmid_state got %b/%h exp 000/00000", {busy, done, alu_own}, {result, flags_out});
        end
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++; $display("FAIL rmid_no_done got %b exp 0", saw_done);
        end
        send_op(OP16_INC, 16'hFFFF, 16'h0000, 4'h3);
        wait_done(lat, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || lat != 3 || {result, flags_out} !== e) begin
            errors++; $display("FAIL rmid_after got %h lat %0d exp %h lat 3", {result, flags_out}, lat, e);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'd0; a_in = 16'h0; b_in = 16'h0; flags_in = 4'h0;
        test_reset();
        test_vectors();
        test_start_ignored();
        test_back_to_back();
        test_random();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d exp 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
